// File: rtl/prm_edge_chk.sv
// prm_edge_chk: sequential cube-table collision checker for PRM roadmap edges.
// Per-sample hits are OR-accumulated into a per-channel edge mask, tracking the first colliding sample.
module prm_edge_chk #(
   parameter int IN_W  = 15,
   parameter int CH    = 4,
   parameter int DEPTH = 64,
   parameter int LANES = 8
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   cfg_we,
   input  logic [$clog2(DEPTH)-1:0]               cfg_addr,
   input  logic [IN_W-1:0]                        cfg_care,
   input  logic [IN_W-1:0]                        cfg_val,
   input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_ch,
   input  logic                                   cfg_en,
   output logic                                   cfg_err,
   input  logic                                   s_valid,
   output logic                                   s_ready,
   input  logic [IN_W-1:0]                        s_data,
   input  logic                                   s_last,
   output logic                                   m_valid,
   input  logic                                   m_ready,
   output logic [CH-1:0]                          m_mask,
   output logic [15:0]                            m_first,
   output logic                                   busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (CH > 1) ? $clog2(CH) : 1;
   localparam int G  = DEPTH / LANES;
   localparam int GW = (G > 1) ? $clog2(G) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, RESULT} state_t;

   state_t              state;
   logic [GW-1:0]       g;
   logic [IN_W-1:0]     x;
   logic                last_f;
   logic [CH-1:0]       smask, hit, smask_n, acc;
   logic [15:0]         cnt, sidx, cnt_inc;
   logic [DEPTH-1:0]    en;
   logic [IN_W-1:0]     care [DEPTH];
   logic [IN_W-1:0]     val  [DEPTH];
   logic [CW-1:0]       ch   [DEPTH];
   logic [AW-1:0]       e;
   logic                wr_ok, grp_last;

   assign s_ready  = (state == IDLE) || (state == DRAIN);
   assign m_valid  = (state == RESULT);
   assign m_mask   = acc;
   assign wr_ok    = cfg_we && !busy;
   assign grp_last = (g == GW'(G - 1));
   assign cnt_inc  = (cnt == 16'hFFFE) ? cnt : cnt + 16'd1;
   assign smask_n  = smask | hit;

   always_comb begin
      hit = '0;
      e   = '0;
      for (int l = 0; l < LANES; l++) begin
         e = AW'(int'(g) * LANES + l);
         if (en[e] && ((x ^ val[e]) & care[e]) == '0 && int'(ch[e]) < CH)
            hit[ch[e]] = 1'b1;
      end
   end

   // Cube payload is deliberately unreset; only the enable bits need clearing.
   always_ff @(posedge clk)
      if (wr_ok) begin
         care[cfg_addr] <= cfg_care;
         val[cfg_addr]  <= cfg_val;
         ch[cfg_addr]   <= cfg_ch;
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state   <= IDLE;
         g       <= '0;
         x       <= '0;
         last_f  <= 1'b0;
         smask   <= '0;
         acc     <= '0;
         m_first <= 16'hFFFF;
         cnt     <= '0;
         sidx    <= '0;
         busy    <= 1'b0;
         cfg_err <= 1'b0;
         en      <= '0;
      end else begin
         cfg_err <= cfg_we && busy;
         if (wr_ok) en[cfg_addr] <= cfg_en;
         case (state)
            IDLE: if (s_valid) begin
               x      <= s_data;
               last_f <= s_last;
               g      <= '0;
               smask  <= '0;
               sidx   <= cnt;
               cnt    <= cnt_inc;
               busy   <= 1'b1;
               state  <= SCAN;
            end
            SCAN: begin
               g     <= g + 1'b1;
               smask <= smask_n;
               if (grp_last) begin
                  acc <= acc | smask_n;
                  if (|smask_n && m_first == 16'hFFFF) m_first <= sidx;
                  state <= last_f ? RESULT : &(acc | smask_n) ? DRAIN : IDLE;
               end
            end
            DRAIN: if (s_valid) begin
               cnt <= cnt_inc;
               if (s_last) state <= RESULT;
            end
            RESULT: if (m_ready) begin
               state   <= IDLE;
               acc     <= '0;
               m_first <= 16'hFFFF;
               cnt     <= '0;
               busy    <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_prm_edge_chk.sv
// tb_prm_edge_chk: directed bench with a result scoreboard for prm_edge_chk.
module tb_prm_edge_chk;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_we = 1'b0;
   logic [5:0]  cfg_addr = '0;
   logic [14:0] cfg_care = '0, cfg_val = '0;
   logic [1:0]  cfg_ch = '0;
   logic        cfg_en = 1'b0;
   logic        cfg_err;
   logic        s_valid = 1'b0, s_ready, s_last = 1'b0;
   logic [14:0] s_data = '0;
   logic        m_valid, m_ready = 1'b0, busy;
   logic [3:0]  m_mask;
   logic [15:0] m_first;

   typedef struct {
      logic [3:0]  mask;
      logic [15:0] first;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0, checks = 0, errors = 0, t_acc = 0, waits = 0;

   prm_edge_chk #(.IN_W(15), .CH(4), .DEPTH(64), .LANES(8)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_care(cfg_care),
      .cfg_val(cfg_val), .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_err(cfg_err),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_mask(m_mask), .m_first(m_first), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg_write(input logic [5:0] a, input logic [14:0] c, input logic [14:0] v,
                            input logic [1:0] h, input logic en);
      cfg_we = 1'b1; cfg_addr = a; cfg_care = c; cfg_val = v; cfg_ch = h; cfg_en = en;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic send(input logic [14:0] d, input logic l);
      s_valid = 1'b1; s_data = d; s_last = l; waits = 0;
      while (!s_ready && waits < 100) begin
         @(negedge clk);
         waits++;
      end
      chk("send_ready", s_ready, 1);
      t_acc = cyc;
      @(negedge clk);
   endtask

   task automatic expect_edge(input logic [3:0] mk, input logic [15:0] fr, input int lat);
      exp_t x;
      x.mask = mk; x.first = fr; x.lat = lat;
      sb.push_back(x);
   endtask

   task automatic get_result(input int hold);
      exp_t x;
      int n = 0;
      s_valid = 1'b0; s_last = 1'b0;
      while (!m_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("result_valid", m_valid, 1);
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: result with no pending expectation");
         return;
      end
      x = sb.pop_front();
      chk("latency", cyc - t_acc, x.lat);
      chk("m_mask", m_mask, x.mask);
      chk("m_first", m_first, x.first);
      chk("s_ready_in_result", s_ready, 0);
      repeat (hold) begin
         @(negedge clk);
         chk("hold_valid", m_valid, 1);
         chk("hold_mask", m_mask, x.mask);
         chk("hold_first", m_first, x.first);
         chk("hold_ready", s_ready, 0);
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      chk("post_ready", s_ready, 1);
      chk("post_first", m_first, 16'hFFFF);
      chk("post_busy", busy, 0);
      chk("post_valid", m_valid, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_mask", m_mask, 0);
      chk("rst_m_first", m_first, 16'hFFFF);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_cfg_err", cfg_err, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // empty table: no hits, scan latency G+1
      send(15'h0000, 1'b0);
      chk("busy_after_accept", busy, 1);
      send(15'h1234, 1'b0);
      expect_edge(4'b0000, 16'hFFFF, 9);
      send(15'h7FFF, 1'b1);
      get_result(0);

      // single exact-match cube on channel 2
      cfg_write(6'd5, 15'h7FFF, 15'h1234, 2'd2, 1'b1);
      send(15'h0000, 1'b0);
      send(15'h1234, 1'b0);
      expect_edge(4'b0100, 16'd1, 9);
      send(15'h0001, 1'b1);
      get_result(0);

      // saturation on sample 0, then drain one sample per cycle
      cfg_write(6'd8,  15'h4000, 15'h4000, 2'd0, 1'b1);
      cfg_write(6'd16, 15'h4000, 15'h4000, 2'd1, 1'b1);
      cfg_write(6'd24, 15'h4000, 15'h4000, 2'd2, 1'b1);
      cfg_write(6'd32, 15'h4000, 15'h4000, 2'd3, 1'b1);
      send(15'h4000, 1'b0);
      send(15'h0001, 1'b0);
      send(15'h0002, 1'b0);
      chk("drain_wait_2", waits, 0);
      send(15'h0003, 1'b0);
      chk("drain_wait_3", waits, 0);
      expect_edge(4'b1111, 16'd0, 1);
      send(15'h0004, 1'b1);
      chk("drain_wait_4", waits, 0);
      get_result(10);

      // write while busy is dropped and flagged
      expect_edge(4'b0000, 16'hFFFF, 9);
      send(15'h0555, 1'b1);
      cfg_write(6'd0, 15'h7FFF, 15'h0555, 2'd3, 1'b1);
      chk("cfg_err_pulse", cfg_err, 1);
      @(negedge clk);
      chk("cfg_err_once", cfg_err, 0);
      get_result(0);

      // same edge with the write issued in IDLE alongside the accept
      cfg_we = 1'b1; cfg_addr = 6'd0; cfg_care = 15'h7FFF; cfg_val = 15'h0555; cfg_ch = 2'd3; cfg_en = 1'b1;
      expect_edge(4'b1000, 16'd0, 9);
      send(15'h0555, 1'b1);
      cfg_we = 1'b0;
      chk("cfg_err_idle", cfg_err, 0);
      get_result(0);

      // asynchronous reset mid-scan abandons the edge and clears the table
      send(15'h4000, 1'b1);
      s_valid = 1'b0; s_last = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_m_valid", m_valid, 0);
      chk("arst_m_mask", m_mask, 0);
      chk("arst_m_first", m_first, 16'hFFFF);
      chk("arst_s_ready", s_ready, 1);
      chk("arst_busy", busy, 0);
      chk("arst_cfg_err", cfg_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      expect_edge(4'b0000, 16'hFFFF, 9);
      send(15'h4000, 1'b1);
      get_result(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
